// File: rtl/thumb_pkg.sv
// Shared types and constants for the Thumb decode stage: opcodes, condition
// codes, immediate-extension kinds and the BL prefix/suffix encodings.
package thumb_pkg;

   localparam int INSTR_W = 16;
   localparam int REG_W   = 4;
   localparam int COND_W  = 4;
   localparam int OP_W    = 6;
   localparam int BL_H_W  = 11;
   localparam int RAW_W   = 2 * BL_H_W;

   localparam logic [4:0]       BL_PREFIX = 5'b11110;
   localparam logic [4:0]       BL_SUFFIX = 5'b11111;
   localparam logic [REG_W-1:0] REG_SP    = 4'd13;
   localparam logic [REG_W-1:0] REG_LR    = 4'd14;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 6'd0,
      OP_ADDS  = 6'd1,
      OP_SUBS  = 6'd2,
      OP_MOVS  = 6'd3,
      OP_ANDS  = 6'd4,
      OP_EORS  = 6'd5,
      OP_LSLS  = 6'd6,
      OP_LSRS  = 6'd7,
      OP_ASRS  = 6'd8,
      OP_RORS  = 6'd9,
      OP_CMP   = 6'd10,
      OP_ORRS  = 6'd11,
      OP_MVNS  = 6'd12,
      OP_MOV   = 6'd13,
      OP_BX    = 6'd14,
      OP_LDR   = 6'd15,
      OP_STR   = 6'd16,
      OP_ADDSP = 6'd17,
      OP_SUBSP = 6'd18,
      OP_BCC   = 6'd19,
      OP_B     = 6'd20,
      OP_BL    = 6'd21,
      OP_UND   = 6'd63
   } opcode_e;

   typedef enum logic [COND_W-1:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   // Zero-extended kinds (Z*), scaled kinds (*X4) and sign-extended branch offsets (S*)
   typedef enum logic [3:0] {
      IMM_NONE = 4'd0,
      IMM_Z3   = 4'd1,
      IMM_Z8   = 4'd2,
      IMM_Z5X4 = 4'd3,
      IMM_Z7X4 = 4'd4,
      IMM_S9   = 4'd5,
      IMM_S12  = 4'd6,
      IMM_S23  = 4'd7
   } imm_kind_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_PREFIX = 1'b1
   } state_e;

endpackage

// File: rtl/thumb_imm_ext.sv
// Immediate extension: zero-extends/scales data immediates and sign-extends
// halfword-scaled branch offsets to DATA_W.
module thumb_imm_ext
   import thumb_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  imm_kind_e         kind,
   input  logic [RAW_W-1:0]  raw,
   output logic [DATA_W-1:0] imm
);

   logic [8:0]  bcc_off;
   logic [11:0] b_off;
   logic [22:0] bl_off;

   assign bcc_off = {raw[7:0], 1'b0};
   assign b_off   = {raw[10:0], 1'b0};
   assign bl_off  = {raw, 1'b0};

   always_comb begin
      imm = '0;
      case (kind)
         IMM_Z3:   imm = {{(DATA_W-3){1'b0}}, raw[2:0]};
         IMM_Z8:   imm = {{(DATA_W-8){1'b0}}, raw[7:0]};
         IMM_Z5X4: imm = {{(DATA_W-7){1'b0}}, raw[4:0], 2'b00};
         IMM_Z7X4: imm = {{(DATA_W-9){1'b0}}, raw[6:0], 2'b00};
         IMM_S9:   imm = {{(DATA_W-9){bcc_off[8]}}, bcc_off};
         IMM_S12:  imm = {{(DATA_W-12){b_off[11]}}, b_off};
         IMM_S23:  imm = {{(DATA_W-23){bl_off[22]}}, bl_off};
         default:  imm = '0;
      endcase
   end

endmodule

// File: rtl/thumb_decode_stage.sv
// Single-stage Thumb halfword decoder with a registered output bundle and a
// two-halfword BL assembler.
//
// state     | meaning
// ST_IDLE   | decoding standalone halfwords
// ST_PREFIX | BL first half held, waiting for the 11111 suffix
module thumb_decode_stage
   import thumb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int ENABLE_BL = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instr,
   input  logic [PC_W-1:0]      in_pc,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output opcode_e              out_op,
   output logic [REG_W-1:0]     out_rd,
   output logic [REG_W-1:0]     out_rn,
   output logic [REG_W-1:0]     out_rm,
   output logic [DATA_W-1:0]    out_imm,
   output logic                 out_use_imm,
   output logic                 out_set_flags,
   output logic [COND_W-1:0]    out_cond,
   output logic [PC_W-1:0]      out_pc,
   output logic                 out_illegal
);

   state_e              state, state_nxt;
   logic                accept, is_prefix, load_prefix, load_bundle;
   logic [BL_H_W-1:0]   pfx_h1;
   logic [PC_W-1:0]     pfx_pc;

   opcode_e             d_op, b_op;
   logic [REG_W-1:0]    d_rd, d_rn, d_rm, b_rd, b_rn, b_rm;
   imm_kind_e           d_kind, b_kind;
   logic [RAW_W-1:0]    d_raw, b_raw;
   logic                d_use_imm, d_set, b_use_imm, b_set, b_ill;
   logic [COND_W-1:0]   d_cond, b_cond;
   logic [PC_W-1:0]     b_pc;
   logic [DATA_W-1:0]   b_imm;

   assign in_ready  = (!out_valid || out_ready) && !flush;
   assign accept    = in_valid && in_ready;
   assign is_prefix = (ENABLE_BL != 0) && (in_instr[15:11] == BL_PREFIX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else if (accept) begin
         case (state)
            ST_IDLE:   if (is_prefix) state_nxt = ST_PREFIX;
            ST_PREFIX: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      load_prefix = 1'b0;
      load_bundle = 1'b0;
      if (accept) begin
         if (state == ST_IDLE && is_prefix) load_prefix = 1'b1;
         else                               load_bundle = 1'b1;
      end
   end

   always_comb begin
      d_op      = OP_UND;
      d_rd      = '0;
      d_rn      = '0;
      d_rm      = '0;
      d_kind    = IMM_NONE;
      d_raw     = {{(RAW_W-INSTR_W){1'b0}}, in_instr};
      d_use_imm = 1'b0;
      d_set     = 1'b0;
      d_cond    = COND_AL;
      casez (in_instr)
         16'b0001_10??_????_????: begin
            d_op  = in_instr[9] ? OP_SUBS : OP_ADDS;
            d_rd  = {1'b0, in_instr[2:0]};
            d_rn  = {1'b0, in_instr[5:3]};
            d_rm  = {1'b0, in_instr[8:6]};
            d_set = 1'b1;
         end
         16'b0001_11??_????_????: begin
            d_op      = in_instr[9] ? OP_SUBS : OP_ADDS;
            d_rd      = {1'b0, in_instr[2:0]};
            d_rn      = {1'b0, in_instr[5:3]};
            d_kind    = IMM_Z3;
            d_raw     = {{(RAW_W-3){1'b0}}, in_instr[8:6]};
            d_use_imm = 1'b1;
            d_set     = 1'b1;
         end
         16'b0010_0???_????_????: begin
            d_op      = OP_MOVS;
            d_rd      = {1'b0, in_instr[10:8]};
            d_kind    = IMM_Z8;
            d_use_imm = 1'b1;
            d_set     = 1'b1;
         end
         16'b0100_00??_????_????: begin
            d_rd  = {1'b0, in_instr[2:0]};
            d_rn  = {1'b0, in_instr[2:0]};
            d_rm  = {1'b0, in_instr[5:3]};
            d_set = 1'b1;
            case (in_instr[9:6])
               4'b0000: d_op = OP_ANDS;
               4'b0001: d_op = OP_EORS;
               4'b0010: d_op = OP_LSLS;
               4'b0011: d_op = OP_LSRS;
               4'b0100: d_op = OP_ASRS;
               4'b0111: d_op = OP_RORS;
               4'b1010: d_op = OP_CMP;
               4'b1100: d_op = OP_ORRS;
               4'b1111: d_op = OP_MVNS;
               default: d_op = OP_UND;
            endcase
         end
         16'b0100_0110_????_????: begin
            d_op = OP_MOV;
            d_rd = {in_instr[7], in_instr[2:0]};
            d_rm = in_instr[6:3];
         end
         16'b0100_0111_0???_?000: begin
            d_op = OP_BX;
            d_rm = in_instr[6:3];
         end
         16'b0110_????_????_????: begin
            d_op      = in_instr[11] ? OP_LDR : OP_STR;
            d_rd      = {1'b0, in_instr[2:0]};
            d_rn      = {1'b0, in_instr[5:3]};
            d_kind    = IMM_Z5X4;
            d_raw     = {{(RAW_W-5){1'b0}}, in_instr[10:6]};
            d_use_imm = 1'b1;
         end
         16'b1011_0000_????_????: begin
            d_op      = in_instr[7] ? OP_SUBSP : OP_ADDSP;
            d_rd      = REG_SP;
            d_rn      = REG_SP;
            d_kind    = IMM_Z7X4;
            d_use_imm = 1'b1;
         end
         16'b1011_1111_0000_0000: d_op = OP_NOP;
         16'b1101_????_????_????: begin
            // 1110 and 1111 in the cond field are UDF/SVC, not branches
            if (in_instr[11:9] != 3'b111) begin
               d_op      = OP_BCC;
               d_cond    = in_instr[11:8];
               d_kind    = IMM_S9;
               d_use_imm = 1'b1;
            end
         end
         16'b1110_0???_????_????: begin
            d_op      = OP_B;
            d_kind    = IMM_S12;
            d_use_imm = 1'b1;
         end
         default: d_op = OP_UND;
      endcase
   end

   always_comb begin
      b_op      = d_op;
      b_rd      = d_rd;
      b_rn      = d_rn;
      b_rm      = d_rm;
      b_kind    = d_kind;
      b_raw     = d_raw;
      b_use_imm = d_use_imm;
      b_set     = d_set;
      b_cond    = d_cond;
      b_pc      = in_pc;
      b_ill     = (d_op == OP_UND);
      if (state == ST_PREFIX) begin
         b_rn      = '0;
         b_rm      = '0;
         b_set     = 1'b0;
         b_cond    = COND_AL;
         b_pc      = pfx_pc;
         b_raw     = {pfx_h1, in_instr[BL_H_W-1:0]};
         if (in_instr[15:11] == BL_SUFFIX) begin
            b_op      = OP_BL;
            b_rd      = REG_LR;
            b_kind    = IMM_S23;
            b_use_imm = 1'b1;
            b_ill     = 1'b0;
         end else begin
            b_op      = OP_UND;
            b_rd      = '0;
            b_kind    = IMM_NONE;
            b_use_imm = 1'b0;
            b_ill     = 1'b1;
         end
      end
   end

   thumb_imm_ext #(.DATA_W(DATA_W)) u_imm_ext (
      .kind (b_kind),
      .raw  (b_raw),
      .imm  (b_imm)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pfx_h1 <= '0;
         pfx_pc <= '0;
      end else if (load_prefix) begin
         pfx_h1 <= in_instr[BL_H_W-1:0];
         pfx_pc <= in_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           out_valid <= 1'b0;
      else if (flush)       out_valid <= 1'b0;
      else if (load_bundle) out_valid <= 1'b1;
      else if (out_ready)   out_valid <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_op        <= OP_NOP;
         out_rd        <= '0;
         out_rn        <= '0;
         out_rm        <= '0;
         out_imm       <= '0;
         out_use_imm   <= 1'b0;
         out_set_flags <= 1'b0;
         out_cond      <= '0;
         out_pc        <= '0;
         out_illegal   <= 1'b0;
      end else if (load_bundle) begin
         out_op        <= b_op;
         out_rd        <= b_rd;
         out_rn        <= b_rn;
         out_rm        <= b_rm;
         out_imm       <= b_imm;
         out_use_imm   <= b_use_imm;
         out_set_flags <= b_set;
         out_cond      <= b_cond;
         out_pc        <= b_pc;
         out_illegal   <= b_ill;
      end
   end

endmodule

// File: doc/thumb_decode_stage.md
THUMB_DECODE_STAGE -- requirements
Module: thumb_decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the immediate/offset output width (min 24).
REQ-002 SHALL have parameter PC_W, default 32, the width of the program-counter tag.
REQ-003 SHALL have parameter ENABLE_BL, default 1; when 1, two-halfword BL is supported.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: in_instr/in_pc valid.
REQ-007 SHALL have port in_ready, output, 1: halfword accepted when in_valid & in_ready.
REQ-008 SHALL have port in_instr, input, 16: Thumb halfword.
REQ-009 SHALL have port in_pc, input, PC_W: address of in_instr.
REQ-010 SHALL have port flush, input, 1: discard pending output and BL prefix.
REQ-011 SHALL have port out_valid, output, 1: decoded bundle valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts bundle.
REQ-013 SHALL have ports out_op (6-bit opcode enum), out_rd/out_rn/out_rm (4 each), out_imm (DATA_W), out_use_imm, out_set_flags, out_cond (4), out_pc (PC_W), out_illegal, all outputs.

Function
REQ-014 SHALL decode: ADDS/SUBS reg and imm3; MOVS imm8; ANDS, EORS, LSLS, LSRS, ASRS, RORS, CMP, ORRS, MVNS; MOV hi-reg; BX Rm; LDR/STR imm5; ADD/SUB SP imm7; NOP; B<cc> imm8; B imm11; BL.
REQ-015 SHALL zero-extend imm3/imm5/imm8 to DATA_W, scale imm5 by 4 and SP imm7 by 4.
REQ-016 SHALL sign-extend branch offsets to DATA_W after a left shift by 1 (B<cc> 9 bits, B 12 bits, BL 23 bits).
REQ-017 SHALL set out_set_flags for every S-suffixed op and CMP only.
REQ-018 SHALL register outputs: bundle appears out_valid the cycle after acceptance (latency 1).
REQ-019 SHALL drive in_ready = !out_valid | out_ready; no combinational path from in_valid to in_ready.
REQ-020 SHALL hold all out_* stable while out_valid & !out_ready.
REQ-021 SHALL implement FSM IDLE/PREFIX: in IDLE, an accepted halfword with [15:11]=11110 (ENABLE_BL=1) stores H1 and in_pc, enters PREFIX, and produces no output.
REQ-022 In PREFIX, an accepted halfword with [15:11]=11111 SHALL emit BL with offset = sign-extend({H1[10:0],H2[10:0],0}), out_rd=14, out_pc=prefix pc, then return to IDLE.
REQ-023 In PREFIX, any other accepted halfword SHALL emit out_illegal=1, out_pc=prefix pc, return to IDLE, and drop that halfword.
REQ-024 An unrecognised encoding, a lone 11111 halfword in IDLE, or 11110 with ENABLE_BL=0 SHALL emit out_op=OP_UND, out_illegal=1.
REQ-025 flush SHALL clear out_valid and return FSM to IDLE next cycle; flush SHALL force in_ready=0 that cycle, so no halfword is accepted.
REQ-026 Simultaneous out_ready and acceptance SHALL replace the bundle in the same edge with no bubble.

Reset
REQ-027 SHALL, on reset low, immediately force out_valid=0, FSM=IDLE, all out_* fields to 0, out_op=OP_NOP.
REQ-028 SHALL, if reset asserts mid-PREFIX, discard the stored prefix; first halfword after release is decoded from IDLE.

Structure
REQ-029 SHALL take the opcode enum, condition codes, field widths and BL prefix constants from shared package thumb_pkg.
REQ-030 SHALL place immediate extension/scaling in sub-module thumb_imm_ext (combinational, DATA_W-parametrised).

Verification
REQ-031 0x235A at pc 0x100, out_ready=1 -> next cycle OP_MOVS, rd=3, imm=0x5A, set_flags=1, out_pc=0x100.
REQ-032 0x18D1 -> OP_ADDS, rd=1, rn=2, rm=3, use_imm=0.
REQ-033 0xD0FE -> OP_BCC, cond=0 (EQ), imm=0xFFFFFFFC.
REQ-034 0xF7FF@0x200 then 0xFFFE -> one bundle OP_BL, imm=0xFFFFFFFC, rd=14, out_pc=0x200; nothing after first halfword.
REQ-035 0xF000 then 0x235A -> out_illegal=1, out_pc=prefix pc; 0x235A not emitted; flush after 0xF000 -> no output, following 0x18D1 decodes normally.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> bundle held stable, in_ready=0, no halfword lost on release.
